// File: rtl/bsg_manycore_loader_arbiter_if.sv
`default_nettype none
// ============================================================================
// bsg_manycore_loader_arbiter_if
// Host-side forward/return bundle shared by the loader arbiter and requesters.
// Revision: 1.0
// ============================================================================
interface bsg_manycore_loader_arbiter_if #(
    parameter int num_req_p   = 2,
    parameter int fwd_width_p = 128,
    parameter int ret_width_p = 64,
    parameter int cnt_width_p = 5
);
    logic [num_req_p-1:0]             req_v_i;
    logic [num_req_p*fwd_width_p-1:0] req_data_i;
    logic [num_req_p-1:0]             req_ready_o;
    logic                             fwd_v_o;
    logic [fwd_width_p-1:0]           fwd_data_o;
    logic                             fwd_ready_i;
    logic                             ret_v_i;
    logic [ret_width_p-1:0]           ret_data_i;
    logic                             ret_ready_o;
    logic [num_req_p-1:0]             ret_v_o;
    logic [ret_width_p-1:0]           ret_data_o;
    logic [num_req_p-1:0]             ret_ready_i;
    logic [num_req_p*cnt_width_p-1:0] out_cnt_o;
    logic                             idle_o;
    logic                             err_o;

    modport master (
        output req_v_i, req_data_i, fwd_ready_i, ret_v_i, ret_data_i, ret_ready_i,
        input  req_ready_o, fwd_v_o, fwd_data_o, ret_ready_o, ret_v_o, ret_data_o,
               out_cnt_o, idle_o, err_o
    );

    modport slave (
        input  req_v_i, req_data_i, fwd_ready_i, ret_v_i, ret_data_i, ret_ready_i,
        output req_ready_o, fwd_v_o, fwd_data_o, ret_ready_o, ret_v_o, ret_data_o,
               out_cnt_o, idle_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/bsg_manycore_loader_arbiter.sv
`default_nettype none
// ============================================================================
// bsg_manycore_loader_arbiter
// Round-robin sharing of the loader link with load_id stamping and credit limits.
// Revision: 1.0
// ============================================================================
module bsg_manycore_loader_arbiter #(
    parameter int num_req_p       = 2,
    parameter int fwd_width_p     = 128,
    parameter int ret_width_p     = 64,
    parameter int fwd_id_lsb_p    = 0,
    parameter int ret_id_lsb_p    = 0,
    parameter int load_id_width_p = 11,
    parameter int max_out_p       = 16
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    bsg_manycore_loader_arbiter_if.slave  bus
);
    localparam int lg_req_lp    = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int cnt_width_lp = (max_out_p > 0) ? $clog2(max_out_p + 1) : 1;
    localparam int fwd_top_lp   = fwd_id_lsb_p + load_id_width_p - 1;
    localparam int ret_top_lp   = ret_id_lsb_p + load_id_width_p - 1;
    localparam logic [cnt_width_lp-1:0] cnt_max_lp = cnt_width_lp'(max_out_p);
    localparam logic [lg_req_lp:0]      num_req_lp = (lg_req_lp + 1)'(num_req_p);

    logic                    r_fwd_v;
    logic [fwd_width_p-1:0]  r_fwd_data;
    logic [lg_req_lp-1:0]    r_ptr;
    logic [cnt_width_lp-1:0] r_cnt [num_req_p];
    logic                    r_err;

    logic [num_req_p-1:0]    w_elig;
    logic                    w_load;
    logic                    w_gnt_v;
    logic                    w_grant;
    logic [lg_req_lp-1:0]    w_gnt_idx;
    logic [lg_req_lp:0]      w_sum;
    logic [lg_req_lp:0]      w_nxt;
    logic [num_req_p-1:0]    w_req_ready;
    logic [fwd_width_p-1:0]  w_stamp;

    logic [lg_req_lp-1:0]    w_ret_idx;
    logic                    w_ret_in;
    logic                    w_ret_zero;
    logic                    w_ret_hs;
    logic                    w_ret_ready;
    logic [num_req_p-1:0]    w_ret_v;
    logic [num_req_p-1:0]    w_dec;
    logic [ret_width_p-1:0]  w_ret_data;
    logic                    w_any_out;

    // The output register can take a new packet if empty or draining this cycle.
    assign w_load = !r_fwd_v || bus.fwd_ready_i;

    always_comb begin
        w_gnt_v   = 1'b0;
        w_gnt_idx = '0;
        w_sum     = '0;
        for (int i = 0; i < num_req_p; i++) begin
            w_elig[i] = bus.req_v_i[i] && (r_cnt[i] < cnt_max_lp);
        end
        for (int k = 0; k < num_req_p; k++) begin
            w_sum = {1'b0, r_ptr} + (lg_req_lp + 1)'(k);
            if (w_sum >= num_req_lp) w_sum = w_sum - num_req_lp;
            if (!w_gnt_v && w_elig[w_sum[lg_req_lp-1:0]]) begin
                w_gnt_v   = 1'b1;
                w_gnt_idx = w_sum[lg_req_lp-1:0];
            end
        end
        w_grant = w_gnt_v && w_load && !reset_i;
        w_nxt   = {1'b0, w_gnt_idx} + 1'b1;
        if (w_nxt >= num_req_lp) w_nxt = '0;
    end

    always_comb begin
        w_req_ready = '0;
        if (w_grant) w_req_ready[w_gnt_idx] = 1'b1;
        w_stamp = bus.req_data_i[w_gnt_idx*fwd_width_p +: fwd_width_p];
        w_stamp[fwd_top_lp -: lg_req_lp] = w_gnt_idx;
    end

    // Out-of-range owners are swallowed: ready is forced high so the link never stalls.
    always_comb begin
        w_ret_idx   = bus.ret_data_i[ret_top_lp -: lg_req_lp];
        w_ret_in    = ({1'b0, w_ret_idx} < num_req_lp);
        w_ret_v     = '0;
        w_ret_ready = 1'b1;
        w_ret_zero  = 1'b0;
        for (int i = 0; i < num_req_p; i++) begin
            if (w_ret_in && (w_ret_idx == lg_req_lp'(i))) begin
                w_ret_v[i]  = bus.ret_v_i && !reset_i;
                w_ret_ready = bus.ret_ready_i[i];
                w_ret_zero  = (r_cnt[i] == '0);
            end
        end
        w_ret_hs = bus.ret_v_i && w_ret_ready;
        for (int i = 0; i < num_req_p; i++) begin
            w_dec[i] = w_ret_hs && w_ret_in && (w_ret_idx == lg_req_lp'(i));
        end
        w_ret_data = bus.ret_data_i;
        w_ret_data[ret_top_lp -: lg_req_lp] = '0;
        w_any_out = 1'b0;
        for (int i = 0; i < num_req_p; i++) begin
            w_any_out = w_any_out || (r_cnt[i] != '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_fwd_v    <= 1'b0;
            r_fwd_data <= '0;
            r_ptr      <= '0;
            r_err      <= 1'b0;
            for (int i = 0; i < num_req_p; i++) r_cnt[i] <= '0;
        end else begin
            if (w_grant) begin
                r_fwd_v    <= 1'b1;
                r_fwd_data <= w_stamp;
                r_ptr      <= w_nxt[lg_req_lp-1:0];
            end else if (bus.fwd_ready_i) begin
                r_fwd_v    <= 1'b0;
            end
            if (w_ret_hs && (!w_ret_in || w_ret_zero)) r_err <= 1'b1;
            for (int i = 0; i < num_req_p; i++) begin
                if (w_grant && (w_gnt_idx == lg_req_lp'(i)) && !w_dec[i]) begin
                    if (r_cnt[i] < cnt_max_lp) r_cnt[i] <= r_cnt[i] + 1'b1;
                end else if (w_dec[i] && !(w_grant && (w_gnt_idx == lg_req_lp'(i)))) begin
                    if (r_cnt[i] != '0) r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < num_req_p; i++) begin : g_cnt
        assign bus.out_cnt_o[i*cnt_width_lp +: cnt_width_lp] = r_cnt[i];
    end

    assign bus.req_ready_o = w_req_ready;
    assign bus.fwd_v_o     = r_fwd_v;
    assign bus.fwd_data_o  = r_fwd_data;
    assign bus.ret_ready_o = w_ret_ready;
    assign bus.ret_v_o     = w_ret_v;
    assign bus.ret_data_o  = w_ret_data;
    assign bus.idle_o      = !w_any_out && !r_fwd_v;
    assign bus.err_o       = r_err;
endmodule
`default_nettype wire

// File: tb/tb_bsg_manycore_loader_arbiter.sv
`default_nettype none
// ============================================================================
// tb_bsg_manycore_loader_arbiter
// Directed bench: two- and three-requester instances with hand-computed vectors.
// Revision: 1.0
// ============================================================================
module tb_bsg_manycore_loader_arbiter;
    logic clk_i;
    logic reset_i;
    int   n_cmp;
    int   n_err;

    bsg_manycore_loader_arbiter_if #(.num_req_p(2), .fwd_width_p(16), .ret_width_p(16), .cnt_width_p(3)) bus2 ();
    bsg_manycore_loader_arbiter_if #(.num_req_p(3), .fwd_width_p(16), .ret_width_p(16), .cnt_width_p(3)) bus3 ();

    bsg_manycore_loader_arbiter #(
        .num_req_p(2), .fwd_width_p(16), .ret_width_p(16), .fwd_id_lsb_p(0),
        .ret_id_lsb_p(0), .load_id_width_p(4), .max_out_p(4)
    ) dut2 (.clk_i(clk_i), .reset_i(reset_i), .bus(bus2));

    bsg_manycore_loader_arbiter #(
        .num_req_p(3), .fwd_width_p(16), .ret_width_p(16), .fwd_id_lsb_p(0),
        .ret_id_lsb_p(0), .load_id_width_p(4), .max_out_p(4)
    ) dut3 (.clk_i(clk_i), .reset_i(reset_i), .bus(bus3));

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset_i = 1'b1;
        bus2.req_v_i = 2'b11;  bus2.req_data_i = {16'h5A50, 16'hA5A0};
        bus2.fwd_ready_i = 1'b1; bus2.ret_v_i = 1'b0; bus2.ret_data_i = '0; bus2.ret_ready_i = 2'b11;
        bus3.req_v_i = '0; bus3.req_data_i = '0; bus3.fwd_ready_i = 1'b0;
        bus3.ret_v_i = 1'b0; bus3.ret_data_i = '0; bus3.ret_ready_i = 3'b111;

        repeat (2) @(posedge clk_i);
        #2;
        chk("rst_req_ready", bus2.req_ready_o, 2'b00);
        chk("rst_fwd_v", bus2.fwd_v_o, 1'b0);
        chk("rst_idle", bus2.idle_o, 1'b1);
        chk("rst_err", bus2.err_o, 1'b0);
        chk("rst_cnt", bus2.out_cnt_o, 6'd0);

        reset_i = 1'b0; #1;
        chk("first_grant", bus2.req_ready_o, 2'b01);

        // Fairness: alternating grants, stamped bit 3 follows the owner.
        tick(); chk("fair1_data", bus2.fwd_data_o, 16'hA5A0); chk("fair1_rdy", bus2.req_ready_o, 2'b10);
        chk("fair1_cnt", bus2.out_cnt_o, {3'd0, 3'd1}); chk("fair1_v", bus2.fwd_v_o, 1'b1);
        tick(); chk("fair2_data", bus2.fwd_data_o, 16'h5A58); chk("fair2_rdy", bus2.req_ready_o, 2'b01);
        tick(); chk("fair3_data", bus2.fwd_data_o, 16'hA5A0); chk("fair3_rdy", bus2.req_ready_o, 2'b10);
        tick(); chk("fair4_data", bus2.fwd_data_o, 16'h5A58); chk("fair4_cnt", bus2.out_cnt_o, {3'd2, 3'd2});

        // Backpressure: register holds, no grants, pointer frozen.
        bus2.fwd_ready_i = 1'b0; #1;
        chk("bp_rdy0", bus2.req_ready_o, 2'b00);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_data", bus2.fwd_data_o, 16'h5A58);
            chk("bp_rdy", bus2.req_ready_o, 2'b00);
            chk("bp_cnt", bus2.out_cnt_o, {3'd2, 3'd2});
        end
        bus2.fwd_ready_i = 1'b1; #1;
        chk("bp_ptr_held", bus2.req_ready_o, 2'b01);
        tick(); chk("bp_rel_data", bus2.fwd_data_o, 16'hA5A0); chk("bp_rel_cnt", bus2.out_cnt_o, {3'd2, 3'd3});

        // Simultaneous grant and return to requester 1.
        bus2.ret_v_i = 1'b1; bus2.ret_data_i = 16'hBEE8; #1;
        chk("sim_rdy", bus2.req_ready_o, 2'b10);
        chk("sim_ret_v", bus2.ret_v_o, 2'b10);
        chk("sim_ret_rdy", bus2.ret_ready_o, 1'b1);
        chk("sim_ret_data", bus2.ret_data_o, 16'hBEE0);
        tick(); chk("sim_cnt", bus2.out_cnt_o, {3'd2, 3'd3}); chk("sim_data", bus2.fwd_data_o, 16'h5A58);
        bus2.req_v_i = 2'b00; bus2.ret_ready_i = 2'b01; #1;
        chk("stall_ret_rdy", bus2.ret_ready_o, 1'b0);
        chk("stall_ret_v", bus2.ret_v_o, 2'b10);
        tick(); chk("stall_cnt", bus2.out_cnt_o, {3'd2, 3'd3}); chk("stall_err", bus2.err_o, 1'b0);
        chk("drain_fwd_v", bus2.fwd_v_o, 1'b0); chk("busy_idle", bus2.idle_o, 1'b0);

        // Credit limit on requester 0.
        bus2.ret_v_i = 1'b0; bus2.ret_ready_i = 2'b11; bus2.req_v_i = 2'b01; #1;
        chk("cr_rdy", bus2.req_ready_o, 2'b01);
        tick(); chk("cr_cnt4", bus2.out_cnt_o, {3'd2, 3'd4}); chk("cr_block", bus2.req_ready_o, 2'b00);
        tick(); chk("cr_block2", bus2.req_ready_o, 2'b00); chk("cr_cnt4b", bus2.out_cnt_o, {3'd2, 3'd4});
        bus2.ret_v_i = 1'b1; bus2.ret_data_i = 16'h1230; #1;
        chk("cr_ret_v", bus2.ret_v_o, 2'b01);
        tick(); bus2.ret_v_i = 1'b0; #1;
        chk("cr_cnt3", bus2.out_cnt_o, {3'd2, 3'd3}); chk("cr_regrant", bus2.req_ready_o, 2'b01);
        tick(); chk("cr_cnt4c", bus2.out_cnt_o, {3'd2, 3'd4}); chk("cr_block3", bus2.req_ready_o, 2'b00);
        bus2.req_v_i = 2'b00;

        // Return to requester 1 with zero outstanding sets the sticky error.
        bus2.ret_v_i = 1'b1; bus2.ret_data_i = 16'h0008;
        tick(); tick(); #1;
        chk("err_pre_cnt", bus2.out_cnt_o, {3'd0, 3'd4});
        chk("err_pre", bus2.err_o, 1'b0);
        chk("err_deliver", bus2.ret_v_o, 2'b10);
        tick(); chk("err_set", bus2.err_o, 1'b1); chk("err_cnt0", bus2.out_cnt_o, {3'd0, 3'd4});
        bus2.ret_data_i = 16'h0000;
        repeat (4) tick();
        bus2.ret_v_i = 1'b0; #1;
        chk("idle_cnt", bus2.out_cnt_o, 6'd0);
        chk("idle", bus2.idle_o, 1'b1);
        chk("err_sticky", bus2.err_o, 1'b1);

        // Three requesters: two-bit stamp and out-of-range return.
        bus3.req_v_i = 3'b100; bus3.req_data_i = {16'hFFF3, 16'h0000, 16'h0000}; bus3.fwd_ready_i = 1'b1; #1;
        chk("r3_rdy", bus3.req_ready_o, 3'b100);
        tick(); chk("r3_stamp", bus3.fwd_data_o, 16'hFFFB); chk("r3_cnt", bus3.out_cnt_o, {3'd1, 3'd0, 3'd0});
        bus3.req_v_i = 3'b000; bus3.ret_v_i = 1'b1; bus3.ret_data_i = 16'h000C; bus3.ret_ready_i = 3'b000; #1;
        chk("r3_oor_rdy", bus3.ret_ready_o, 1'b1);
        chk("r3_oor_v", bus3.ret_v_o, 3'b000);
        chk("r3_err_pre", bus3.err_o, 1'b0);
        tick(); chk("r3_err", bus3.err_o, 1'b1); chk("r3_cnt_keep", bus3.out_cnt_o, {3'd1, 3'd0, 3'd0});
        bus3.ret_v_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/bsg_manycore_loader_arbiter.md
Name: bsg_manycore_loader_arbiter

Overview:
- Shares the single manycore loader/IO link between num_req_p host-side requesters, for example the PCIe host path and a debug/DMA engine.
- Forward packets from requesters are round-robin arbitrated into a one-entry output register. The requester index is stamped into reserved load_id bits.
- Return packets are steered back to the originating requester by those bits.
- A per-requester outstanding-request counter throttles each requester.

Parameters:
- num_req_p, 2, number of requesters (≥2).
- fwd_width_p, 128, forward packet width in bits.
- ret_width_p, 64, return packet width in bits.
- fwd_id_lsb_p, 0, bit position of load_id field in forward packet.
- ret_id_lsb_p, 0, bit position of load_id field in return packet.
- load_id_width_p, 11, load_id width; top lg_req_lp=`BSG_SAFE_CLOG2(num_req_p) bits are reserved for the requester index.
- max_out_p, 16, maximum outstanding requests per requester.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- req_v_i  in  num_req_p  forward request valid per requester.
- req_data_i  in  num_req_p*fwd_width_p  forward packets.
- req_ready_o  out  num_req_p  forward accept per requester.
- fwd_v_o  out  1  packet valid toward loader link.
- fwd_data_o  out  fwd_width_p  packet with stamped load_id.
- fwd_ready_i  in  1  loader link accepts.
- ret_v_i  in  1  return packet valid from loader link.
- ret_data_i  in  ret_width_p  return packet.
- ret_ready_o  out  1  return accept.
- ret_v_o  out  num_req_p  return valid, one-hot to owner.
- ret_data_o  out  ret_width_p  return packet broadcast, reserved bits cleared to 0.
- ret_ready_i  in  num_req_p  requester accepts return.
- out_cnt_o  out  num_req_p*`BSG_SAFE_CLOG2(max_out_p+1)  outstanding count per requester.
- idle_o  out  1  no outstanding requests and output register empty.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset values: fwd_v_o=0, req_ready_o=0, ret_v_o=0, all counters=0, round-robin pointer=0, err_o=0, idle_o=1. Registers are cleared synchronously, and any in-flight output-register contents are discarded.
- Eligibility: requester i is eligible when req_v_i[i]=1 and out_cnt[i]<max_out_p.
- Grant: at most one grant per cycle, only when the output register is empty or fwd_ready_i=1 in that cycle (pass-through refill). Selection is round-robin starting at the pointer; after grant i the pointer becomes (i+1) mod num_req_p. The pointer is unchanged when there is no grant.
- req_ready_o[i]=1 only for the granted requester, combinational from inputs and state. A requester can never be granted without a valid.
- Stamping: the registered packet equals req_data_i[g] with bits [fwd_id_lsb_p+load_id_width_p-1 -: lg_req_lp] replaced by g.
- Latency: packet appears on fwd_v_o the cycle after acceptance. It holds stable while fwd_ready_i=0.
- Return steering: idx = ret_data_i[ret_id_lsb_p+load_id_width_p-1 -: lg_req_lp]. ret_v_o[idx]=ret_v_i, ret_ready_o=ret_ready_i[idx]. Combinational, zero latency.
- Counters: out_cnt[i] increments on grant to i and decrements on a return handshake to i. Simultaneous increment and decrement leaves it unchanged. Counters saturate at 0 and max_out_p and never wrap.
- Errors:
  - A return with idx≥num_req_p is accepted (ret_ready_o=1) and dropped, with no ret_v_o; err_o sets.
  - A return to a requester with out_cnt=0 is delivered, the counter stays 0, and err_o sets.
  - err_o clears only on reset.
- idle_o = all counters 0 and fwd_v_o=0.

Test Plan:
- Reset: assert reset_i 2 cycles with req_v_i=2'b11 → req_ready_o=0, fwd_v_o=0, idle_o=1. The first cycle after reset grants requester 0.
- Fairness: num_req_p=2, both valid continuously, fwd_ready_i=1 → grants alternate 0,1,0,1. fwd_data_o load_id top bit alternates 0,1. One packet per cycle with no bubbles.
- Backpressure: fwd_ready_i=0 for 5 cycles with one packet held → fwd_data_o stable, req_ready_o=0. The pointer does not advance until the register frees.
- Credit limit: max_out_p=4, requester 0 only, no returns → exactly 4 grants and out_cnt[0]=4, then req_ready_o[0]=0. One return to requester 0 → out_cnt 3, next cycle one more grant.
- Simultaneous: grant and return to requester 1 in the same cycle at out_cnt=2 → stays 2. ret_ready_i[1]=0 stalls ret_ready_o=0 and the counter is unchanged.
- Error: return with idx=1 while out_cnt[1]=0 → delivered, err_o=1 next cycle and sticky. With num_req_p=3, idx=3 → dropped, ret_ready_o=1, err_o=1.
